// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline skid stage: occupancy width, the FSM
// state encoding and a helper that decodes a state into its entry count.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int OCC_W = 2;

   // Encoding matches the number of held entries so occupancy is a direct decode.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   function automatic logic [OCC_W-1:0] occupancy_of(input skid_state_t st);
      case (st)
         ST_BUSY: occupancy_of = 2'd1;
         ST_FULL: occupancy_of = 2'd2;
         default: occupancy_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry valid/ready pipeline register (main + skid) between pipeline
// stages. o_in_ready is decoded from registered state only, so there is no
// combinational path from i_out_ready back upstream. Output always comes from
// the main register; the skid register catches the one entry that arrives in
// the cycle the output stalls.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_flush               synchronous flush, overrides all handshakes
//   i_in_valid/o_in_ready upstream handshake, i_in_data/i_in_ctrl payload
//   o_out_valid/i_out_ready downstream handshake, o_out_data/o_out_ctrl head
//   o_occupancy           held entries (0..2)
//   o_stall_cnt           saturating count of stalled-output cycles
// -----------------------------------------------------------------------------
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W        = 96,
   parameter int CTRL_W        = 3,
   parameter int ZERO_ON_FLUSH = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [CTRL_W-1:0] i_in_ctrl,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CTRL_W-1:0] o_out_ctrl,
   output logic [OCC_W-1:0]  o_occupancy,
   output logic [15:0]       o_stall_cnt
);

   skid_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_data_q, skid_data_q;
   logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
   logic [15:0]       stall_cnt_q;
   logic              in_fire, out_fire;

   assign o_in_ready  = (state_q != ST_FULL);
   assign o_out_valid = (state_q != ST_EMPTY);
   assign in_fire     = i_in_valid & o_in_ready;
   assign out_fire    = o_out_valid & i_out_ready;

   // Control is masked on bubbles so a stale regwen can never reach writeback.
   assign o_out_data  = main_data_q;
   assign o_out_ctrl  = o_out_valid ? main_ctrl_q : '0;
   assign o_occupancy = occupancy_of(state_q);
   assign o_stall_cnt = stall_cnt_q;

   // NOTE: every output of a combinational block gets a default before any
   // branch; a path that leaves state_d unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (in_fire) state_d = ST_BUSY;
         ST_BUSY: begin
            if (in_fire && !out_fire)      state_d = ST_FULL;
            else if (!in_fire && out_fire) state_d = ST_EMPTY;
         end
         ST_FULL:  if (out_fire) state_d = ST_BUSY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   // NOTE: the payload registers are reset (not just valid) because the
   // outputs must read zero during and after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else if (i_flush) begin
         // Any input offered this cycle is dropped; a concurrent out_fire
         // has already been consumed downstream.
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         skid_ctrl_q <= '0;
         if (ZERO_ON_FLUSH != 0) begin
            main_data_q <= '0;
            skid_data_q <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_data_q <= i_in_data;
                  main_ctrl_q <= i_in_ctrl;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  main_data_q <= i_in_data;
                  main_ctrl_q <= i_in_ctrl;
               end else if (in_fire) begin
                  // Head is stalled: park the newcomer behind it.
                  skid_data_q <= i_in_data;
                  skid_ctrl_q <= i_in_ctrl;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_data_q <= skid_data_q;
                  main_ctrl_q <= skid_ctrl_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Stall counter ignores flush; only reset clears it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_q <= '0;
      end else if (o_out_valid && !i_out_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning payload width (pc, inst, alu packed).
REQ-002 The block SHALL have parameter CTRL_W, default 3, meaning control width (wb_sel, regwen); control is cleared on flush.
REQ-003 The block SHALL have parameter ZERO_ON_FLUSH, default 1, meaning that when 1 the payload registers are zeroed on flush and when 0 only control and valid are cleared.
REQ-004 The block SHALL have port i_clk  in  1  clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port i_flush  in  1  synchronous flush, sampled on rising edge.
REQ-007 The block SHALL have port i_in_valid  in  1  upstream entry valid.
REQ-008 The block SHALL have port o_in_ready  out  1  stage can accept an entry this cycle.
REQ-009 The block SHALL have port i_in_data  in  DATA_W  upstream payload.
REQ-010 The block SHALL have port i_in_ctrl  in  CTRL_W  upstream control.
REQ-011 The block SHALL have port o_out_valid  out  1  downstream entry valid.
REQ-012 The block SHALL have port i_out_ready  in  1  downstream accepts the entry.
REQ-013 The block SHALL have port o_out_data  out  DATA_W  head payload.
REQ-014 The block SHALL have port o_out_ctrl  out  CTRL_W  head control.
REQ-015 The block SHALL have port o_occupancy  out  2  number of held entries (0..2).
REQ-016 The block SHALL have port o_stall_cnt  out  16  count of cycles with output stalled.

Function
REQ-017 in_fire SHALL be i_in_valid & o_in_ready, and out_fire SHALL be o_out_valid & i_out_ready.
REQ-018 The FSM SHALL have states EMPTY (occupancy 0), BUSY (occupancy 1, main register), FULL (occupancy 2, main plus skid register).
REQ-019 EMPTY: in_fire SHALL load main and go to BUSY; otherwise the FSM SHALL stay in EMPTY.
REQ-020 BUSY: in_fire & out_fire SHALL load main from input and stay in BUSY; in_fire & !out_fire SHALL load skid and go to FULL; out_fire only SHALL go to EMPTY; neither SHALL hold.
REQ-021 FULL: out_fire SHALL move skid into main and go to BUSY; otherwise the FSM SHALL hold; no input is accepted in FULL.
REQ-022 o_in_ready SHALL be 1 exactly when the state is not FULL, decoded from registered state with no combinational path from i_out_ready.
REQ-023 o_out_valid SHALL be 1 in BUSY and FULL, and o_out_data/o_out_ctrl SHALL always come from main.
REQ-024 o_out_ctrl SHALL be forced to 0 whenever o_out_valid=0, so that regwen is never asserted on a bubble.
REQ-025 Latency SHALL be 1 cycle: an entry accepted in EMPTY appears on the output the next cycle.
REQ-026 Throughput SHALL be one entry per cycle when i_out_ready=1 continuously.
REQ-027 Ordering SHALL be strict FIFO: skid is never presented before main.
REQ-028 Flush SHALL have priority over all handshakes: next state EMPTY, main and skid control zeroed, and payload zeroed if ZERO_ON_FLUSH=1.
REQ-029 An input offered in the same cycle as a flush SHALL be discarded, and an out_fire in the flush cycle SHALL still count as consumed downstream.
REQ-030 o_stall_cnt SHALL increment each cycle with o_out_valid & !i_out_ready, saturate at 16'hFFFF, be unaffected by flush, and clear only on reset.
REQ-031 The held payload and control SHALL be stable while o_out_valid & !i_out_ready.

Reset
REQ-032 On i_rst, state SHALL be EMPTY, main and skid payload/control 0, and o_stall_cnt 0, taking effect immediately without waiting for a clock.
REQ-033 During and after reset the outputs SHALL be o_out_valid=0, o_out_data=0, o_out_ctrl=0, o_occupancy=0, o_in_ready=1.
REQ-034 Reset asserted mid-transfer SHALL drop all held entries, with no partial entry surviving.

Structure
REQ-035 Package pipe_pkg SHALL hold the state enum type (EMPTY/BUSY/FULL) and the occupancy width constant.
REQ-036 The block SHALL have no sub-module: the two payload registers and the FSM are flat in pipe_skid_stage.

Verification
REQ-037 Reset release, then in_valid with data 0x...A5 and ctrl 3'b101 while EMPTY SHALL give next cycle out_valid=1, data A5, ctrl 101, occupancy 1.
REQ-038 Streaming 8 entries 1..8 with out_ready=1 SHALL give outputs 1..8 on consecutive cycles, o_in_ready always 1, and o_stall_cnt 0.
REQ-039 Holding out_ready=0 while sending 3 entries SHALL give: the first two accepted, occupancy 2, o_in_ready=0, the third held upstream; after out_ready=1, order SHALL be 1,2,3.
REQ-040 Asserting flush in FULL with in_valid=1 SHALL give next cycle occupancy 0, out_valid=0, and out_ctrl=0, the input SHALL be discarded, and data SHALL be 0 when ZERO_ON_FLUSH=1.
REQ-041 Stalling output for 70000 cycles SHALL saturate o_stall_cnt at 0xFFFF, and a subsequent flush SHALL not clear it.
REQ-042 Asserting i_rst asynchronously between clock edges in FULL SHALL give outputs zero and o_in_ready=1 before the next edge.
